// File: rtl/fc_layer_mac_pkg.sv
// Shared definitions for the fully-connected MAC engine (fc_layer_mac).
// The optional argmax output is built only when FC_LAYER_ARGMAX_EN is defined.
package fc_layer_mac_pkg;

    localparam int FC_DEF_BW     = 32'sd8;
    localparam int FC_DEF_SIZE   = 32'sd5;
    localparam int FC_DEF_CI     = 32'sd12;
    localparam int FC_DEF_CO     = 32'sd10;
    localparam int FC_DEF_ACC_BW = 32'sd25;
    localparam int FC_DEF_N      = FC_DEF_CI * FC_DEF_SIZE * FC_DEF_SIZE;
    localparam int FC_DEF_WCNT   = FC_DEF_CI * FC_DEF_CO * FC_DEF_SIZE * FC_DEF_SIZE;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MAC   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_EMIT  = 3'd3,
        ST_DONE  = 3'd4
    } fc_state_e;

    // Ceiling log2, never narrower than one bit.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 32'sd0;
        v = value - 32'sd1;
        while (v > 32'sd0) begin
            r = r + 32'sd1;
            v = v >>> 1;
        end
        if (r == 32'sd0) begin
            r = 32'sd1;
        end
        return r;
    endfunction

    function automatic int acc_bw_min(input int bw, input int n);
        return 32'sd2 * bw + clog2(n);
    endfunction

endpackage

// File: rtl/fc_mac_unit.sv
// Signed BW x BW multiplier with a registered product feeding an ACC_BW
// accumulator; clr empties both the product and the accumulator.
module fc_mac_unit #(
    parameter int BW     = 8,
    parameter int ACC_BW = 25
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     prod_en,
    input  logic                     acc_en,
    input  logic signed [BW-1:0]     a,
    input  logic signed [BW-1:0]     b,
    output logic signed [ACC_BW-1:0] acc_sum
);

    logic signed [2*BW-1:0]   prod_r;
    logic signed [ACC_BW-1:0] acc_r;

    assign acc_sum = acc_r + {{(ACC_BW - 2*BW){prod_r[2*BW-1]}}, prod_r};

    // Product pipeline register and running sum.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            prod_r <= '0;
            acc_r  <= '0;
        end else begin
            if (prod_en) begin
                prod_r <= a * b;
            end
            if (acc_en) begin
                acc_r <= acc_sum;
            end
        end
    end

endmodule

// File: rtl/fc_layer_mac.sv
// Fully-connected layer engine: CO signed dot products of length CI*SIZE*SIZE,
// one MAC per cycle. Define FC_LAYER_ARGMAX_EN to add the o_class argmax output.
module fc_layer_mac
    import fc_layer_mac_pkg::*;
#(
    parameter int BW     = FC_DEF_BW,
    parameter int SIZE   = FC_DEF_SIZE,
    parameter int CI     = FC_DEF_CI,
    parameter int CO     = FC_DEF_CO,
    parameter int ACC_BW = FC_DEF_ACC_BW
) (
    input  logic                             clk,
    input  logic                             global_rst,
    input  logic                             rst_processEnd,
    input  logic                             i_start,
    input  logic                             i_weight_full,
    input  logic [CI*CO*SIZE*SIZE*BW-1:0]    i_weight,
    input  logic [CI*SIZE*SIZE*BW-1:0]       i_feature,
    output logic [ACC_BW-1:0]                o_data,
    output logic [clog2(CO)-1:0]             o_index,
    output logic                             o_valid,
    output logic                             o_busy,
`ifdef FC_LAYER_ARGMAX_EN
    output logic [clog2(CO)-1:0]             o_class,
`endif
    output logic                             o_done
);

    localparam int N      = CI * SIZE * SIZE;
    localparam int WCNT   = CI * CO * SIZE * SIZE;
    localparam int N_W    = clog2(N);
    localparam int CO_W   = clog2(CO);
    localparam int WIDX_W = clog2(WCNT);

    if (ACC_BW < acc_bw_min(BW, N)) begin : g_acc_bw_check
        $error("fc_layer_mac: ACC_BW is too narrow for BW and N");
    end

    fc_state_e                state_r;
    logic [N_W-1:0]           n_r;
    logic [CO_W-1:0]          co_r;
    logic [N*BW-1:0]          feat_r;
    logic signed [BW-1:0]     w_arr_s [WCNT];
    logic signed [BW-1:0]     x_arr_s [N];
    logic [WIDX_W-1:0]        w_idx_s;
    logic                     rst_s;
    logic                     mac_clr_s;
    logic                     prod_en_s;
    logic                     acc_en_s;
    logic signed [ACC_BW-1:0] acc_sum_s;

    for (genvar k = 0; k < WCNT; k++) begin : g_w_unpack
        assign w_arr_s[k] = i_weight[k*BW +: BW];
    end
    for (genvar k = 0; k < N; k++) begin : g_x_unpack
        assign x_arr_s[k] = feat_r[k*BW +: BW];
    end

    assign rst_s   = global_rst | rst_processEnd;
    assign w_idx_s = WIDX_W'(co_r) * WIDX_W'(N) + WIDX_W'(n_r);

    fc_mac_unit #(
        .BW     (BW),
        .ACC_BW (ACC_BW)
    ) u_mac (
        .clk     (clk),
        .rst     (rst_s),
        .clr     (mac_clr_s),
        .prod_en (prod_en_s),
        .acc_en  (acc_en_s),
        .a       (w_arr_s[w_idx_s]),
        .b       (x_arr_s[n_r]),
        .acc_sum (acc_sum_s)
    );

    // MAC datapath controls derived from the current state.
    always_comb begin
        mac_clr_s = 1'b0;
        prod_en_s = 1'b0;
        acc_en_s  = 1'b0;
        case (state_r)
            ST_MAC: begin
                prod_en_s = 1'b1;
                acc_en_s  = 1'b1;
            end
            ST_DRAIN: acc_en_s  = 1'b1;
            ST_IDLE:  mac_clr_s = 1'b1;
            ST_EMIT:  mac_clr_s = 1'b1;
            ST_DONE:  mac_clr_s = 1'b1;
            default:  mac_clr_s = 1'b1;
        endcase
    end

    // Sequencer FSM with registered result and status outputs.
    always_ff @(posedge clk) begin
        if (rst_s) begin
            state_r <= ST_IDLE;
            n_r     <= '0;
            co_r    <= '0;
            feat_r  <= '0;
            o_data  <= '0;
            o_index <= '0;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            o_done  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (i_start && i_weight_full) begin
                        feat_r  <= i_feature;
                        n_r     <= '0;
                        co_r    <= '0;
                        o_busy  <= 1'b1;
                        state_r <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (n_r == N_W'(N - 1)) begin
                        n_r     <= '0;
                        state_r <= ST_DRAIN;
                    end else begin
                        n_r <= n_r + N_W'(1);
                    end
                end
                ST_DRAIN: begin
                    // The final product is folded in here so the result is visible during EMIT.
                    o_data  <= acc_sum_s;
                    o_index <= co_r;
                    o_valid <= 1'b1;
                    state_r <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (co_r == CO_W'(CO - 1)) begin
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        co_r    <= co_r + CO_W'(1);
                        state_r <= ST_MAC;
                    end
                end
                ST_DONE: state_r <= ST_IDLE;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

`ifdef FC_LAYER_ARGMAX_EN
    logic signed [ACC_BW-1:0] best_r;
    logic [CO_W-1:0]          best_idx_r;
    logic                     take_s;
    logic [CO_W-1:0]          class_next_s;

    // Strict greater-than keeps the lower index on ties.
    always_comb begin
        take_s = (co_r == CO_W'(0)) || ($signed(o_data) > best_r);
        if (take_s) begin
            class_next_s = co_r;
        end else begin
            class_next_s = best_idx_r;
        end
    end

    // Running best score and index, published at the end of the inference.
    always_ff @(posedge clk) begin
        if (rst_s) begin
            best_r     <= '0;
            best_idx_r <= '0;
            o_class    <= '0;
        end else if (state_r == ST_EMIT) begin
            if (take_s) begin
                best_r     <= $signed(o_data);
                best_idx_r <= co_r;
            end
            if (co_r == CO_W'(CO - 1)) begin
                o_class <= class_next_s;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fc_layer_mac.sv
// Randomised self-checking bench for fc_layer_mac against a plain-arithmetic
// dot-product model; o_class is also checked when FC_LAYER_ARGMAX_EN is defined.
module tb_fc_layer_mac;

    localparam int BW     = 8;
    localparam int SIZE   = 5;
    localparam int CI     = 12;
    localparam int CO     = 10;
    localparam int ACC_BW = 25;
    localparam int N      = CI * SIZE * SIZE;
    localparam int WCNT   = N * CO;
    localparam int PERIOD = N + 2;

    typedef struct {
        int data;
        int idx;
        int cyc;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   global_rst;
    logic                   rst_processEnd;
    logic                   i_start;
    logic                   i_weight_full;
    logic [WCNT*BW-1:0]     i_weight;
    logic [N*BW-1:0]        i_feature;
    logic [ACC_BW-1:0]      o_data;
    logic [3:0]             o_index;
    logic                   o_valid;
    logic                   o_busy;
    logic                   o_done;
`ifdef FC_LAYER_ARGMAX_EN
    logic [3:0]             o_class;
`endif

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   w_m [WCNT];
    int   x_m [N];
    exp_t exp_q [$];
    int   t0 = 0;
    int   done_cyc = -1;
    bit   run_active = 1'b0;
    bit   chk_en = 1'b0;
    int   last_d = 0;
    int   last_i = 0;
    int   exp_class = 0;

    fc_layer_mac dut (
        .clk            (clk),
        .global_rst     (global_rst),
        .rst_processEnd (rst_processEnd),
        .i_start        (i_start),
        .i_weight_full  (i_weight_full),
        .i_weight       (i_weight),
        .i_feature      (i_feature),
        .o_data         (o_data),
        .o_index        (o_index),
        .o_valid        (o_valid),
        .o_busy         (o_busy),
`ifdef FC_LAYER_ARGMAX_EN
        .o_class        (o_class),
`endif
        .o_done         (o_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic load_bus();
        for (int k = 0; k < WCNT; k++) i_weight[k*BW +: BW] = w_m[k][BW-1:0];
        for (int k = 0; k < N; k++) i_feature[k*BW +: BW] = x_m[k][BW-1:0];
    endtask

    // Accepts a run at the next falling edge and fills the scoreboard from the arrays.
    task automatic start_run();
        int best_s;
        @(negedge clk);
        load_bus();
        i_start       = 1'b1;
        i_weight_full = 1'b1;
        t0            = cyc;
        done_cyc      = t0 + CO * PERIOD + 1;
        run_active    = 1'b1;
        best_s        = 0;
        for (int co = 0; co < CO; co++) begin
            int s;
            s = 0;
            for (int n = 0; n < N; n++) s += w_m[co*N + n] * x_m[n];
            exp_q.push_back('{s, co, t0 + (co + 1) * PERIOD});
            if (co == 0 || s > best_s) begin
                best_s    = s;
                exp_class = co;
            end
        end
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic finish_run();
        while (cyc <= done_cyc + 2) @(negedge clk);
        chk("all_strobes_seen", exp_q.size(), 0);
    endtask

    task automatic fill_random();
        for (int k = 0; k < WCNT; k++) w_m[k] = int'($urandom_range(255)) - 128;
        for (int k = 0; k < N; k++) x_m[k] = int'($urandom_range(255)) - 128;
    endtask

    // Per-cycle comparison of every output against the scoreboard.
    always begin
        bit exp_v;
        @(posedge clk);
        #2;
        if (chk_en) begin
            exp_v = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            if (exp_v) begin
                last_d = exp_q[0].data;
                last_i = exp_q[0].idx;
                void'(exp_q.pop_front());
            end
            chk("o_valid", o_valid, exp_v);
            chk("o_data", $signed(o_data), last_d);
            chk("o_index", o_index, last_i);
            chk("o_busy", o_busy, run_active && cyc > t0 && cyc < done_cyc);
            chk("o_done", o_done, run_active && cyc == done_cyc);
`ifdef FC_LAYER_ARGMAX_EN
            if (run_active && cyc == done_cyc) chk("o_class", o_class, exp_class);
`endif
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        global_rst     = 1'b1;
        rst_processEnd = 1'b0;
        i_start        = 1'b0;
        i_weight_full  = 1'b0;
        i_weight       = '0;
        i_feature      = '0;
        repeat (3) @(negedge clk);
        chk("rst_o_data", $signed(o_data), 0);
        chk("rst_o_index", o_index, 0);
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_busy", o_busy, 0);
        chk("rst_o_done", o_done, 0);
        global_rst = 1'b0;
        chk_en     = 1'b1;

        // Start without a full weight buffer must be ignored.
        i_start = 1'b1;
        repeat (4) @(negedge clk);
        i_start = 1'b0;
        chk("notfull_busy", o_busy, 0);

        // All ones; features zeroed after acceptance; extra start while busy.
        for (int k = 0; k < WCNT; k++) w_m[k] = 1;
        for (int k = 0; k < N; k++) x_m[k] = 1;
        start_run();
        chk("model_ones", exp_q[0].data, 300);
        while (cyc < t0 + 10) @(negedge clk);
        i_feature = '0;
        while (cyc < t0 + 50) @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        while (o_valid !== 1'b1 && cyc < t0 + 400) @(negedge clk);
        chk("first_valid_at", cyc - t0, 302);
        while (o_done !== 1'b1 && cyc < t0 + 3100) @(negedge clk);
        chk("done_at", cyc - t0, 3021);
        finish_run();

        // Sign extension: large positive and large negative products.
        for (int k = 0; k < WCNT; k++) w_m[k] = -128;
        for (int k = 0; k < N; k++) x_m[k] = -128;
        start_run();
        chk("model_neg_neg", exp_q[0].data, 4915200);
        finish_run();
        for (int k = 0; k < N; k++) x_m[k] = 127;
        start_run();
        chk("model_neg_pos", exp_q[0].data, -4876800);
        finish_run();

        // Per-neuron weight co-5 with features 2.
        for (int k = 0; k < WCNT; k++) w_m[k] = k / N - 5;
        for (int k = 0; k < N; k++) x_m[k] = 2;
        start_run();
        chk("model_ramp_first", exp_q[0].data, -3000);
        chk("model_ramp_last", exp_q[9].data, 2400);
`ifdef FC_LAYER_ARGMAX_EN
        chk("model_class", exp_class, 9);
`endif
        finish_run();

        // Soft clear mid-inference abandons the run.
        fill_random();
        start_run();
        while (cyc < t0 + 500) @(negedge clk);
        rst_processEnd = 1'b1;
        exp_q.delete();
        run_active = 1'b0;
        last_d     = 0;
        last_i     = 0;
        @(negedge clk);
        rst_processEnd = 1'b0;
        chk("abort_o_data", $signed(o_data), 0);
        chk("abort_o_busy", o_busy, 0);
        chk("abort_o_valid", o_valid, 0);
        repeat (400) @(negedge clk);

        // Random restarts after the abort.
        for (int r = 0; r < 2; r++) begin
            fill_random();
            start_run();
            finish_run();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
